uart_rx_param: RTL
==================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL provide parameter CLK_FREQ, default 50_000_000, clock frequency in Hz.
REQ-002 SHALL provide parameter BIT_RATE, default 9600, line rate in bit/s; CPB = CLK_FREQ/BIT_RATE (integer division, CPB >= 8).
REQ-003 SHALL provide parameter PAYLOAD_WIDTH, default 8, data bits per frame, legal 5..9.
REQ-004 SHALL provide parameter STOP_BITS, default 1, stop bits checked, legal 1 or 2.
REQ-005 SHALL provide parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity.
REQ-006 SHALL provide parameter FIFO_DEPTH, default 4, receive FIFO entries, power of 2, >= 2.
REQ-007 SHALL provide port clk, input, 1, single clock; all logic on the rising edge.
REQ-008 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL provide port uart_rxd, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL provide port uart_rx_en, input, 1, receiver enable.
REQ-011 SHALL provide port rx_data, output, PAYLOAD_WIDTH, FIFO head word.
REQ-012 SHALL provide port rx_valid, output, 1, FIFO non-empty.
REQ-013 SHALL provide port rx_ready, input, 1, consumer pops the head when rx_valid && rx_ready.
REQ-014 SHALL provide port rx_level, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-015 SHALL provide port rx_break, output, 1, one-cycle pulse per detected break.
REQ-016 SHALL provide ports rx_frame_err, rx_parity_err and rx_overrun, each output, 1, sticky error flags.
REQ-017 SHALL provide port err_clr, input, 1, clears all sticky flags.

Function
REQ-018 SHALL pass uart_rxd through a two-flop synchronizer; all sampling uses the second-flop output (rxd_s).
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP, with a cycle counter sized $clog2(CPB)+1.
REQ-020 IDLE -> START when rxd_s == 0 and uart_rx_en == 1; the counter clears.
REQ-021 START: at count CPB/2-1, rxd_s == 0 -> DATA with counter cleared; rxd_s == 1 -> IDLE (false start, no flags).
REQ-022 DATA: each data bit SHALL be sampled at count CPB-1 (mid-bit), LSB first; after PAYLOAD_WIDTH bits go to PARITY (macro defined) or STOP.
REQ-023 PARITY: the bit SHALL be sampled at CPB-1; a mismatch against computed parity marks the frame parity-bad.
REQ-024 STOP: STOP_BITS stop bits SHALL be sampled at CPB-1 each; any 0 marks the frame frame-bad.
REQ-025 After the last stop sample, the FSM SHALL go to IDLE in the next cycle and SHALL accept a new start bit immediately.
REQ-026 Break: all data bits 0 and the first stop bit 0 SHALL pulse rx_break for one cycle, push no data and not set rx_frame_err; the FSM SHALL hold in IDLE until rxd_s == 1.
REQ-027 A good frame SHALL push to the FIFO on the cycle after the last stop sample.
REQ-028 A frame-bad or parity-bad frame SHALL be discarded and SHALL set the matching sticky flag.
REQ-029 rx_valid SHALL assert one cycle after a push into an empty FIFO.
REQ-030 The FIFO SHALL be show-ahead, so rx_data = head whenever rx_valid = 1.
REQ-031 A push when full and without a pop SHALL drop the new word and set rx_overrun.
REQ-032 A simultaneous push and pop when full SHALL accept both, leaving rx_level unchanged.
REQ-033 A pop while empty SHALL be ignored.
REQ-034 A flag set SHALL win over err_clr in the same cycle.
REQ-035 Deasserting uart_rx_en SHALL abort any in-progress frame to IDLE with no push and no flags; FIFO contents and the pop path SHALL remain operational.

Reset
REQ-036 On rst_n low, asynchronously: state IDLE; counters 0; synchronizer flops 1; FIFO empty; rx_valid 0, rx_level 0, rx_data 0; rx_break and all sticky flags 0.
REQ-037 Reset mid-frame SHALL discard the frame; after release the first start is recognized only after rxd_s has been seen 1.

Configuration
REQ-038 Macro UART_RX_PARITY_EN: defined -> PARITY state present, parity checked per PARITY_ODD, rx_parity_err functional.
REQ-039 Macro UART_RX_PARITY_EN undefined -> PARITY state removed, frame = start + data + stop, rx_parity_err tied 0.

Verification (CLK_FREQ=1_000_000, BIT_RATE=100_000, CPB=10, macro defined, even parity, FIFO_DEPTH=4)
REQ-040 Frame 0xA5 with parity 0 and stop 1, rx_ready=1 -> rx_data=0xA5 and rx_valid high for 1 cycle, no flags.
REQ-041 3-cycle low glitch on idle line -> no state beyond START, no push, no flags.
REQ-042 Frames 0x01..0x05 with rx_ready=0 -> rx_level=4, rx_overrun=1; pops yield 0x01,0x02,0x03,0x04.
REQ-043 Frame 0x3C with wrong parity 1 -> no push, rx_parity_err=1; err_clr pulse -> 0.
REQ-044 Line low for 20 bit times -> single rx_break pulse, rx_frame_err=0, no push; next 0x55 frame received correctly.
REQ-045 rst_n low during data bit 4 of 0xFF -> all outputs 0; subsequent 0x81 frame received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param -- parameterised UART receiver with show-ahead receive FIFO.
//
// Build option: define UART_RX_PARITY_EN to insert a parity bit between the
// data bits and the stop bit(s), checked as even (PARITY_ODD=0) or odd
// (PARITY_ODD=1). Without it the frame is start + data + stop and
// rx_parity_err is tied low.
//
// Ports
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   uart_rxd       serial line (asynchronous, idle high)
//   uart_rx_en     receiver enable; dropping it aborts the frame in flight
//   rx_data        FIFO head word (zero while the FIFO is empty)
//   rx_valid       FIFO non-empty
//   rx_ready       consumer pops the head when rx_valid && rx_ready
//   rx_level       FIFO occupancy
//   rx_break       one-cycle pulse per detected break condition
//   rx_frame_err   sticky: frame discarded for a low stop bit
//   rx_parity_err  sticky: frame discarded for a parity mismatch
//   rx_overrun     sticky: completed frame dropped because the FIFO was full
//   err_clr        clears all sticky flags (a same-cycle set wins)
module uart_rx_param #(
   parameter int CLK_FREQ      = 50_000_000,
   parameter int BIT_RATE      = 9600,
   parameter int PAYLOAD_WIDTH = 8,
   parameter int STOP_BITS     = 1,
   parameter int PARITY_ODD    = 0,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          uart_rxd,
   input  logic                          uart_rx_en,
   output logic [PAYLOAD_WIDTH-1:0]      rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level,
   output logic                          rx_break,
   output logic                          rx_frame_err,
   output logic                          rx_parity_err,
   output logic                          rx_overrun,
   input  logic                          err_clr
);

   localparam int CPB   = CLK_FREQ / BIT_RATE;
   localparam int CNT_W = $clog2(CPB) + 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int BW    = $clog2(PAYLOAD_WIDTH);

   localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CPB / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
   localparam logic [BW-1:0]    BIT_LAST  = BW'(PAYLOAD_WIDTH - 1);
   localparam logic             STOP_LAST = (STOP_BITS == 2);
   localparam logic [AW:0]      FULL_LVL  = (AW + 1)'(FIFO_DEPTH);

   // An out-of-range parameter set keeps the receiver idle rather than
   // producing corrupted words.
   localparam logic CFG_OK = (CPB >= 8) &&
                             (PAYLOAD_WIDTH >= 5) && (PAYLOAD_WIDTH <= 9) &&
                             (STOP_BITS == 1 || STOP_BITS == 2) &&
                             (PARITY_ODD == 0 || PARITY_ODD == 1) &&
                             (FIFO_DEPTH >= 2) &&
                             ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   // ---------------------------------------------------------------------
   // Input synchronizer
   // ---------------------------------------------------------------------
   logic sync1, rxd_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         sync1 <= uart_rxd;
         rxd_s <= sync1;
      end
   end

   // ---------------------------------------------------------------------
   // Receive FSM
   // ---------------------------------------------------------------------
   state_t                   state, state_n;
   logic [CNT_W-1:0]         cnt, cnt_n;
   logic [BW-1:0]            bit_idx, bit_n;
   logic                     stop_idx, stop_n;
   logic [PAYLOAD_WIDTH-1:0] shreg, shreg_n;
   logic                     frm_bad, frm_bad_n;
   logic                     frame_fail;
   // armed: line has been seen high since reset or the last break, so a
   // falling edge may be taken as a start bit.
   logic                     armed, armed_n;
   logic                     push_q, push_n;
   logic                     brk_q, brk_n;
   logic                     frm_set_q, frm_set_n;
`ifdef UART_RX_PARITY_EN
   localparam logic PAR_ODD = (PARITY_ODD != 0);
   logic                     par_bad, par_bad_n;
   logic                     par_set_q, par_set_n;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         shreg     <= '0;
         frm_bad   <= 1'b0;
         armed     <= 1'b0;
         push_q    <= 1'b0;
         brk_q     <= 1'b0;
         frm_set_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad   <= 1'b0;
         par_set_q <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_idx   <= bit_n;
         stop_idx  <= stop_n;
         shreg     <= shreg_n;
         frm_bad   <= frm_bad_n;
         armed     <= armed_n;
         push_q    <= push_n;
         brk_q     <= brk_n;
         frm_set_q <= frm_set_n;
`ifdef UART_RX_PARITY_EN
         par_bad   <= par_bad_n;
         par_set_q <= par_set_n;
`endif
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt + 1'b1;
      bit_n      = bit_idx;
      stop_n     = stop_idx;
      shreg_n    = shreg;
      frm_bad_n  = frm_bad;
      armed_n    = armed;
      push_n     = 1'b0;
      brk_n      = 1'b0;
      frm_set_n  = 1'b0;
      frame_fail = frm_bad | ~rxd_s;
`ifdef UART_RX_PARITY_EN
      par_bad_n  = par_bad;
      par_set_n  = 1'b0;
`endif

      case (state)
         S_IDLE: begin
            cnt_n     = '0;
            bit_n     = '0;
            stop_n    = 1'b0;
            frm_bad_n = 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_n = 1'b0;
`endif
            if (rxd_s)
               armed_n = 1'b1;
            if (!rxd_s && armed && uart_rx_en && CFG_OK)
               state_n = S_START;
         end

         S_START: begin
            if (cnt == CNT_HALF) begin
               cnt_n   = '0;
               state_n = rxd_s ? S_IDLE : S_DATA;
            end
         end

         S_DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_n   = '0;
               shreg_n = {rxd_s, shreg[PAYLOAD_WIDTH-1:1]};
               if (bit_idx == BIT_LAST) begin
                  bit_n = '0;
`ifdef UART_RX_PARITY_EN
                  state_n = S_PARITY;
`else
                  state_n = S_STOP;
`endif
               end else begin
                  bit_n = bit_idx + 1'b1;
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt == CNT_LAST) begin
               cnt_n     = '0;
               par_bad_n = rxd_s ^ (^shreg) ^ PAR_ODD;
               state_n   = S_STOP;
            end
         end
`endif

         S_STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_n = '0;
               if (!stop_idx && !rxd_s && (shreg == '0)) begin
                  // Break: report it once, then wait for the line to go
                  // high before looking for another start bit.
                  brk_n   = 1'b1;
                  armed_n = 1'b0;
                  state_n = S_IDLE;
               end else if (stop_idx == STOP_LAST) begin
                  state_n   = S_IDLE;
                  frm_set_n = frame_fail;
`ifdef UART_RX_PARITY_EN
                  par_set_n = par_bad;
                  push_n    = !frame_fail && !par_bad;
`else
                  push_n    = !frame_fail;
`endif
               end else begin
                  stop_n    = 1'b1;
                  frm_bad_n = frame_fail;
               end
            end
         end

         default: state_n = S_IDLE;
      endcase

      // Disable aborts the frame silently; the FIFO side is unaffected.
      if (state != S_IDLE && !uart_rx_en) begin
         state_n   = S_IDLE;
         cnt_n     = '0;
         push_n    = 1'b0;
         brk_n     = 1'b0;
         frm_set_n = 1'b0;
`ifdef UART_RX_PARITY_EN
         par_set_n = 1'b0;
`endif
      end
   end

   assign rx_break = brk_q;

   // ---------------------------------------------------------------------
   // Receive FIFO (show-ahead)
   // ---------------------------------------------------------------------
   logic [PAYLOAD_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]            wr_ptr, rd_ptr;
   logic [AW:0]              level;
   logic                     do_pop, do_push, full, overrun_set;

   assign full        = (level == FULL_LVL);
   assign do_pop      = rx_ready && rx_valid;
   assign do_push     = push_q && (!full || do_pop);
   assign overrun_set = push_q && full && !do_pop;

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   assign rx_valid = (level != '0);
   assign rx_level = level;
   assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

   // ---------------------------------------------------------------------
   // Sticky error flags
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
      end else begin
         if (frm_set_q)
            rx_frame_err <= 1'b1;
         else if (err_clr)
            rx_frame_err <= 1'b0;
         if (overrun_set)
            rx_overrun <= 1'b1;
         else if (err_clr)
            rx_overrun <= 1'b0;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rx_parity_err <= 1'b0;
      else if (par_set_q)
         rx_parity_err <= 1'b1;
      else if (err_clr)
         rx_parity_err <= 1'b0;
   end
`else
   assign rx_parity_err = 1'b0;
`endif

endmodule
